// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 default timing and the pattern-mode encodings.
package vga_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {
        MODE_VBARS  = 2'd0,
        MODE_HBARS  = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, horizontal/vertical counters and the sync/active/frame-end
// decode taken from the current (pre-advance) counter values.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = cnt_width(H_TOTAL + 1),
    localparam int VW      = cnt_width(V_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_pix_en,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_hs_act,
    output logic          o_vs_act,
    output logic          o_active,
    output logic          o_frame_end
);

    localparam int DW = cnt_width(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] r_div_cnt;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_pix_en;
    logic          w_h_last;
    logic          w_v_last;

    // With CLK_DIV = 1 the divider is a constant zero and pix_en never drops.
    assign w_pix_en = (r_div_cnt == DIV_LAST);
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
        end else begin
            r_div_cnt <= w_pix_en ? '0 : r_div_cnt + 1'b1;
            if (w_pix_en) begin
                r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
                if (w_h_last) begin
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
                end
            end
        end
    end

    assign o_pix_en    = w_pix_en;
    assign o_h_cnt     = r_h_cnt;
    assign o_v_cnt     = r_v_cnt;
    assign o_hs_act    = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
    assign o_vs_act    = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
    assign o_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_frame_end = w_pix_en && w_h_last && w_v_last;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: four selectable patterns, registered syncs and RGB,
// with mode and scroll offset latched only at the frame boundary.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int COLOR_BITS  = 1,
    parameter int CHECK_SIZE  = 32,
    parameter int SCROLL_STEP = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    output logic                    vga_hs_l,
    output logic                    vga_vs_l,
    output logic [3*COLOR_BITS-1:0] vga_rgb,
    output logic                    frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = cnt_width(H_TOTAL + 1);
    localparam int VW      = cnt_width(V_TOTAL + 1);
    localparam int CB_BIT  = $clog2(CHECK_SIZE);

    localparam logic [HW-1:0] H_BAR  = HW'(H_ACTIVE / 8);
    localparam logic [VW-1:0] V_BAR  = VW'(V_ACTIVE / 8);
    localparam logic [HW:0]   H_ACT1 = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   STEP1  = (HW+1)'(SCROLL_STEP);

    if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
        $error("vga_pattern_gen: H_ACTIVE must be a multiple of 8");
    end
    if (V_ACTIVE % 8 != 0) begin : g_bad_v_active
        $error("vga_pattern_gen: V_ACTIVE must be a multiple of 8");
    end
    if (CHECK_SIZE < 1 || (CHECK_SIZE & (CHECK_SIZE - 1)) != 0) begin : g_bad_check
        $error("vga_pattern_gen: CHECK_SIZE must be a power of 2");
    end
    if (SCROLL_STEP >= H_ACTIVE) begin : g_bad_step
        $error("vga_pattern_gen: SCROLL_STEP must be below H_ACTIVE");
    end

    logic                    w_pix_en;
    logic [HW-1:0]           w_h_cnt;
    logic [VW-1:0]           w_v_cnt;
    logic                    w_hs_act;
    logic                    w_vs_act;
    logic                    w_active;
    logic                    w_frame_end;

    mode_e                   r_mode;
    logic [HW-1:0]           r_scroll;
    logic                    r_hs_l;
    logic                    r_vs_l;
    logic [3*COLOR_BITS-1:0] r_rgb;
    logic                    r_frame_start;

    logic [HW:0]             w_scroll_sum;
    logic [HW-1:0]           w_scroll_next;
    logic [HW:0]             w_col_sum;
    logic [HW-1:0]           w_col_eff;
    logic                    w_chk;
    logic [2:0]              w_color;
    logic [3*COLOR_BITS-1:0] w_rgb;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .o_pix_en    (w_pix_en),
        .o_h_cnt     (w_h_cnt),
        .o_v_cnt     (w_v_cnt),
        .o_hs_act    (w_hs_act),
        .o_vs_act    (w_vs_act),
        .o_active    (w_active),
        .o_frame_end (w_frame_end)
    );

    // Offsets stay below H_ACTIVE, so a single conditional subtract is a full modulo.
    assign w_scroll_sum  = {1'b0, r_scroll} + STEP1;
    assign w_scroll_next = (w_scroll_sum >= H_ACT1) ? HW'(w_scroll_sum - H_ACT1)
                                                    : w_scroll_sum[HW-1:0];

    always_comb begin
        w_col_sum = {1'b0, w_h_cnt} + {1'b0, r_scroll};
        w_col_eff = (w_col_sum >= H_ACT1) ? HW'(w_col_sum - H_ACT1) : w_col_sum[HW-1:0];
        w_chk     = w_h_cnt[CB_BIT] ^ w_v_cnt[CB_BIT];
        w_color   = 3'b000;
        case (r_mode)
            MODE_VBARS:  w_color = 3'(w_h_cnt / H_BAR);
            MODE_HBARS:  w_color = 3'(w_v_cnt / V_BAR);
            MODE_CHECK:  w_color = {3{w_chk}};
            MODE_SCROLL: w_color = 3'(w_col_eff / H_BAR);
            default:     w_color = 3'b000;
        endcase
        w_rgb = {{COLOR_BITS{w_color[2]}}, {COLOR_BITS{w_color[1]}}, {COLOR_BITS{w_color[0]}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode        <= MODE_VBARS;
            r_scroll      <= '0;
            r_hs_l        <= 1'b1;
            r_vs_l        <= 1'b1;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_end;
            if (w_pix_en) begin
                r_hs_l <= ~w_hs_act;
                r_vs_l <= ~w_vs_act;
                r_rgb  <= w_active ? w_rgb : '0;
            end
            if (w_frame_end) begin
                r_mode   <= mode_e'(mode);
                r_scroll <= w_scroll_next;
            end
        end
    end

    assign vga_hs_l    = r_hs_l;
    assign vga_vs_l    = r_vs_l;
    assign vga_rgb     = r_rgb;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a scaled-down raster (80x22 total, 64x16 active)
// so that many frames, mode switches and a full scroll wrap fit in a short run.
module tb_vga_pattern_gen;

    localparam int T_CLK_DIV = 2;
    localparam int T_HA      = 64;
    localparam int T_HFP     = 4;
    localparam int T_HS      = 8;
    localparam int T_HBP     = 4;
    localparam int T_VA      = 16;
    localparam int T_VFP     = 2;
    localparam int T_VS      = 2;
    localparam int T_VBP     = 2;
    localparam int T_CB      = 2;
    localparam int T_CHK     = 8;
    localparam int T_STEP    = 4;

    localparam int H_TOT    = T_HA + T_HFP + T_HS + T_HBP;
    localparam int V_TOT    = T_VA + T_VFP + T_VS + T_VBP;
    localparam int FRAME    = H_TOT * V_TOT;
    localparam int RGB_W    = 3 * T_CB;
    localparam int WAIT_MAX = 4 * FRAME * T_CLK_DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             vga_hs_l;
    logic             vga_vs_l;
    logic [RGB_W-1:0] vga_rgb;
    logic             frame_start;

    int checks   = 0;
    int failures = 0;

    vga_pattern_gen #(
        .CLK_DIV     (T_CLK_DIV),
        .H_ACTIVE    (T_HA),
        .H_FP        (T_HFP),
        .H_SYNC      (T_HS),
        .H_BP        (T_HBP),
        .V_ACTIVE    (T_VA),
        .V_FP        (T_VFP),
        .V_SYNC      (T_VS),
        .V_BP        (T_VBP),
        .COLOR_BITS  (T_CB),
        .CHECK_SIZE  (T_CHK),
        .SCROLL_STEP (T_STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .vga_hs_l    (vga_hs_l),
        .vga_vs_l    (vga_vs_l),
        .vga_rgb     (vga_rgb),
        .frame_start (frame_start)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The display is a linear scan: after the n-th pixel slot since reset the pins
    // show raster pixel n-1; frame f uses the mode seen at the end of frame f-1 and
    // a scroll offset of f*STEP modulo the active width.
    int         k = 0;
    int         cur_h = 0;
    int         cur_v = 0;
    int         cur_f = 0;
    bit         cur_valid = 1'b0;
    logic [1:0] fm [0:63];
    logic             exp_hs = 1'b1;
    logic             exp_vs = 1'b1;
    logic             exp_fs = 1'b0;
    logic [RGB_W-1:0] exp_rgb = '0;

    function automatic logic [RGB_W-1:0] model_rgb(input int h, input int v, input int f,
                                                   input logic [1:0] m);
        int c;
        int col;
        logic [RGB_W-1:0] rgb;
        if (h >= T_HA || v >= T_VA) return '0;
        case (m)
            2'd0:    c = h / (T_HA / 8);
            2'd1:    c = v / (T_VA / 8);
            2'd2:    c = (((h / T_CHK) + (v / T_CHK)) % 2 == 1) ? 7 : 0;
            default: begin
                col = (h + (f * T_STEP) % T_HA) % T_HA;
                c   = col / (T_HA / 8);
            end
        endcase
        rgb = '0;
        for (int b = 0; b < 3; b++) begin
            if (c[b]) rgb = rgb | RGB_W'(((1 << T_CB) - 1) << (b * T_CB));
        end
        return rgb;
    endfunction

    always @(posedge clk) begin
        int n;
        int p;
        if (rst) begin
            k     = 0;
            fm[0] = 2'd0;
        end else begin
            k = k + 1;
            if (k % T_CLK_DIV == 0 && (k / T_CLK_DIV) % FRAME == 0)
                fm[(k / T_CLK_DIV) / FRAME] = mode;
        end
        n = k / T_CLK_DIV;
        cur_valid = (n > 0);
        if (n > 0) begin
            p       = n - 1;
            cur_f   = p / FRAME;
            cur_h   = (p % FRAME) % H_TOT;
            cur_v   = (p % FRAME) / H_TOT;
            exp_hs  = !(cur_h >= T_HA + T_HFP && cur_h < T_HA + T_HFP + T_HS);
            exp_vs  = !(cur_v >= T_VA + T_VFP && cur_v < T_VA + T_VFP + T_VS);
            exp_rgb = model_rgb(cur_h, cur_v, cur_f, fm[cur_f]);
            exp_fs  = (k % T_CLK_DIV == 0) && (n % FRAME == 0);
        end else begin
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
            exp_rgb = '0;
            exp_fs  = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [RGB_W+2:0] exp_v;
        logic [RGB_W+2:0] act_v;
        if (rst || !cur_valid) exp_v = {1'b1, 1'b1, 1'b0, {RGB_W{1'b0}}};
        else                   exp_v = {exp_hs, exp_vs, exp_fs, exp_rgb};
        act_v  = {vga_hs_l, vga_vs_l, frame_start, vga_rgb};
        checks = checks + 1;
        if (act_v !== exp_v) begin
            failures = failures + 1;
            $display("FAIL cycle t=%0t h=%0d v=%0d f=%0d {hs,vs,fs,rgb} got=%b want=%b",
                     $time, cur_h, cur_v, cur_f, act_v, exp_v);
        end
    end

    // ---------------- sync shape monitor (first two frames) ----------------
    int   cyc = 0;
    int   hs_run = 0;
    int   vs_run = 0;
    int   hs_lo_min = 1 << 30;
    int   hs_lo_max = 0;
    int   per_min = 1 << 30;
    int   per_max = 0;
    int   vs_lo_last = 0;
    int   last_fall = -1;
    logic prev_hs = 1'b1;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && cur_valid && cur_f < 2) begin
            if (vga_hs_l === 1'b0) hs_run = hs_run + 1;
            else if (hs_run > 0) begin
                if (hs_run < hs_lo_min) hs_lo_min = hs_run;
                if (hs_run > hs_lo_max) hs_lo_max = hs_run;
                hs_run = 0;
            end
            if (prev_hs === 1'b1 && vga_hs_l === 1'b0) begin
                if (last_fall >= 0) begin
                    if (cyc - last_fall < per_min) per_min = cyc - last_fall;
                    if (cyc - last_fall > per_max) per_max = cyc - last_fall;
                end
                last_fall = cyc;
            end
            if (vga_vs_l === 1'b0) vs_run = vs_run + 1;
            else if (vs_run > 0) begin
                vs_lo_last = vs_run;
                vs_run     = 0;
            end
        end
        prev_hs = vga_hs_l;
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_px(input int h, input int v, input int f, output bit ok);
        ok = 1'b0;
        for (int g = 0; g < WAIT_MAX; g++) begin
            @(negedge clk);
            if (cur_valid && cur_h == h && cur_v == v && cur_f == f) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL wait_px pixel (%0d,%0d) frame %0d not reached within %0d cycles",
                     h, v, f, WAIT_MAX);
        end
    endtask

    task automatic check_px(input int h, input int v, input int f,
                            input logic [RGB_W-1:0] exp, input string name);
        bit ok;
        wait_px(h, v, f, ok);
        if (ok) chk(name, 32'(vga_rgb), 32'(exp));
    endtask

    task automatic reset_now(input string name);
        #2 rst = 1'b1;
        #1;
        chk({name, "_hs"},  32'(vga_hs_l),    32'd1);
        chk({name, "_vs"},  32'(vga_vs_l),    32'd1);
        chk({name, "_rgb"}, 32'(vga_rgb),     32'd0);
        chk({name, "_fs"},  32'(frame_start), 32'd0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_hs",  32'(vga_hs_l),    32'd1);
        chk("reset_vs",  32'(vga_vs_l),    32'd1);
        chk("reset_rgb", 32'(vga_rgb),     32'd0);
        chk("reset_fs",  32'(frame_start), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // vertical bars
        check_px(0,  0, 0, 6'b000000, "m0_px0");
        check_px(7,  0, 0, 6'b000000, "m0_px7");
        check_px(8,  0, 0, 6'b000011, "m0_px8");
        check_px(63, 0, 0, 6'b111111, "m0_px63");
        wait_px(0, 3, 0, ok);
        mode = 2'd1;
        check_px(8,  5, 0, 6'b000011, "m0_hold_after_mode_write");

        // horizontal bars
        check_px(5,  1, 1, 6'b000000, "m1_line1");
        check_px(5,  2, 1, 6'b000011, "m1_line2");
        check_px(5, 15, 1, 6'b111111, "m1_line15");
        mode = 2'd2;

        // checkerboard
        check_px(7, 0, 2, 6'b000000, "m2_7_0");
        check_px(8, 0, 2, 6'b111111, "m2_8_0");
        check_px(8, 8, 2, 6'b000000, "m2_8_8");
        mode = 2'd3;
        chk("hs_low_min_clk",   32'(hs_lo_min),  32'(T_HS * T_CLK_DIV));
        chk("hs_low_max_clk",   32'(hs_lo_max),  32'(T_HS * T_CLK_DIV));
        chk("hs_period_min",    32'(per_min),    32'(H_TOT * T_CLK_DIV));
        chk("hs_period_max",    32'(per_max),    32'(H_TOT * T_CLK_DIV));
        chk("vs_low_clk",       32'(vs_lo_last), 32'(T_VS * H_TOT * T_CLK_DIV));

        // scroll: offset is 4*frame, so frame 3 -> 12, frame 5 -> 20
        check_px(4, 0, 3, 6'b001100, "m3_f3_px4");
        check_px(4, 0, 5, 6'b001111, "m3_f5_px4");

        // random mode changes during frames 6..13
        while (cur_f < 14) begin
            repeat ($urandom_range(50, 3000)) begin
                @(negedge clk);
                if (cur_f >= 14) break;
            end
            mode = 2'($urandom_range(0, 3));
        end
        mode = 2'd3;

        // offset 60 in frame 15, wrapped to 0 in frame 16
        check_px(3, 0, 15, 6'b111111, "m3_f15_px3");
        check_px(4, 0, 15, 6'b000000, "m3_f15_px4_wrap");
        check_px(4, 0, 16, 6'b000000, "m3_f16_px4");
        check_px(8, 0, 16, 6'b000011, "m3_f16_px8");
        mode = 2'd0;

        // mid-frame switch 0 -> 2 only lands at the next frame
        wait_px(0, 10, 17, ok);
        mode = 2'd2;
        check_px(8, 12, 17, 6'b000011, "switch_hold");
        check_px(8, 0, 18, 6'b111111, "switch_apply");

        // reset in the middle of an active line
        wait_px(8, 3, 18, ok);
        reset_now("rst_active");
        check_px(8, 0, 0, 6'b000011, "post_rst1_mode_r0");

        // reset while both syncs are asserted
        wait_px(70, 18, 0, ok);
        reset_now("rst_sync");
        check_px(8, 0, 0, 6'b000011, "post_rst2_px8");

        repeat (100) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(95000 * 10);
        failures = failures + 1;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA test-pattern generator: owns its pixel-rate divider and horizontal/vertical timing, produces active-low syncs and a blanked RGB bus at configurable colour depth. It provides four run-time-selectable patterns, including an animated scrolling pattern. Mode changes are applied only at frame boundaries. It sits directly behind the board VGA connector as a bring-up and monitor-check source.

## Interface
- CLK_DIV, 2: clk cycles per pixel (≥1); pixel enable fires once every CLK_DIV cycles
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines
- COLOR_BITS, 1: bits per colour channel
- CHECK_SIZE, 32: checkerboard square edge in pixels (power of 2)
- SCROLL_STEP, 4: pixels scrolled per frame in mode 3 (< H_ACTIVE)
- clk  in  1  system clock; one clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  pattern select (0 vbars, 1 hbars, 2 checker, 3 scroll); sampled at frame end
- vga_hs_l  out  1  horizontal sync, active low
- vga_vs_l  out  1  vertical sync, active low
- vga_rgb  out  3*COLOR_BITS  {R,G,B}, each channel COLOR_BITS wide
- frame_start  out  1  one-clk pulse when timing wraps to pixel (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- div_cnt counts 0..CLK_DIV-1; pix_en = (div_cnt == CLK_DIV-1). All timing state advances only on pix_en edges.
- h_cnt 0..H_TOTAL-1 wraps to 0; v_cnt increments on h wrap and wraps at V_TOTAL.
- Sync: hs active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; vs uses the same rule on v_cnt.
- active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE; rgb forced to 0 when not active.
- 3-bit colour index c = {R,G,B}. Each bit is replicated COLOR_BITS times into its channel.
  - Mode 0: c = h_cnt / (H_ACTIVE/8).
  - Mode 1: c = v_cnt / (V_ACTIVE/8).
  - Mode 2: c = 3'b111 if bit log2(CHECK_SIZE) of h_cnt XOR the same bit of v_cnt is 1, else 3'b000.
  - Mode 3: col_eff = h_cnt + scroll_off, minus H_ACTIVE if ≥ H_ACTIVE; c = col_eff / (H_ACTIVE/8).
- Frame end is the pix_en edge with h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1. On that edge:
  - mode_r ← mode;
  - scroll_off ← scroll_off + SCROLL_STEP, minus H_ACTIVE if the sum is ≥ H_ACTIVE;
  - frame_start is set for exactly one clk cycle.
- scroll_off advances every frame regardless of mode. The pattern is selected by mode_r, never by raw mode.
- Elaboration-time checks: H_ACTIVE % 8 == 0, V_ACTIVE % 8 == 0, CHECK_SIZE a power of 2, SCROLL_STEP < H_ACTIVE, CLK_DIV ≥ 1.

## Timing
- Reset values: div_cnt = 0, h_cnt = 0, v_cnt = 0, mode_r = 0, scroll_off = 0, vga_hs_l = 1, vga_vs_l = 1, vga_rgb = 0, frame_start = 0.
- Outputs are registered. On a pix_en edge, hs/vs/rgb load from the pre-advance counter values, so pixel (h,v) appears one edge after the counters hold it. Each output value is then held for CLK_DIV cycles.
- Sync and rgb share the pipeline stage, so they are always mutually aligned. Latency from counter state to pins is 1 clk.
- First pix_en after reset deassertion occurs at the CLK_DIV-th rising edge. Outputs then show pixel (0,0).
- A mode change mid-frame has no visible effect until the first pixel of the next frame.
- Reset asserted mid-frame immediately drives all outputs and state to reset values, with no partial-line completion.
- CLK_DIV = 1: pix_en is constantly high and every clk is a pixel.

## Structure
- Shared package vga_pkg holds the 640x480@60 default timing constants and the mode encodings MODE_VBARS, MODE_HBARS, MODE_CHECK and MODE_SCROLL.
- Sub-module vga_timing holds the divider, h/v counters, sync decode, active and frame-end flags.
- vga_pattern_gen instantiates vga_timing and holds the pattern logic, scroll_off, mode_r and the output registers.

## Test plan
- Reset, then run 2 frames with defaults: hs low for 96 pixels (192 clk), period 800 pixels; vs low for 2 lines; rgb = 0 throughout blanking.
- Mode 0, pixels 0, 79, 80, 639 of line 0: rgb = 000, 000, 001, 111. With COLOR_BITS = 2, pixel 80 gives 6'b000011.
- Mode 1: line 59 = 000, line 60 = 001, line 479 = 111.
- Mode 2: (31,0) = 000, (32,0) = 111, (32,32) = 000.
- Mode 3, SCROLL_STEP = 4: in frame n = 0..3, pixel 76 = 000, 001, 001, 001. After 160 frames scroll_off wraps to 0.
- Switch mode 0→2 at line 200, and assert rst mid-line: the pattern change appears only at the next (0,0), with frame_start a one-clk pulse. rst immediately forces hs_l = vs_l = 1 and rgb = 0, and the timing restarts at (0,0).
